// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end types: PC width, default reset vector and the fetch FIFO entry.
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] DEFAULT_RESET_VECTOR = '0;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic            fault;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_buffer_if.sv
// Instruction memory request/response bus: pipelined req/gnt with in-order rvalid responses.
interface ifetch_buffer_if;
  import riscv_pkg::*;

  logic            req;
  logic [XLEN-1:0] adr;
  logic            gnt;
  logic            rvalid;
  logic [31:0]     rdata;
  logic            err;

  modport master (output req, adr, input gnt, rvalid, rdata, err);
  modport slave  (input req, adr, output gnt, rvalid, rdata, err);

endinterface

// File: rtl/ifetch_fifo.sv
// Fetch entry FIFO: push/pop/clear, no bypass; clear wins over a same-cycle push or pop.
module ifetch_fifo
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear_i,
  input  logic         push_i,
  input  fetch_entry_t data_i,
  input  logic         pop_i,
  output fetch_entry_t head_o,
  output logic [CW-1:0] count_o
);

  fetch_entry_t          entries_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  pop_ok;

  // Popping an empty FIFO is a no-op so decode may hold ready high freely.
  assign pop_ok = pop_i && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok) rd_ptr_d = rd_ptr_q + AW'(1);
      if (push_i && !pop_ok) begin
        count_d = count_q + CW'(1);
      end else if (!push_i && pop_ok) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) entries_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_i && !clear_i) entries_q[wr_ptr_q] <= data_i;
    end
  end

  assign head_o  = entries_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/ifetch_buffer.sv
// Instruction fetch front-end: sequential PC, credit-limited pipelined imem requests,
// response FIFO toward decode, and branch flush that discards in-flight responses.
module ifetch_buffer
  import riscv_pkg::*;
#(
  parameter int unsigned     DEPTH        = 4,
  parameter logic [XLEN-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              branch_v_i,
  input  logic [XLEN-1:0]   branch_adr_i,
  ifetch_buffer_if.master   imem,
  output logic              instr_v_o,
  input  logic              instr_ready_i,
  output logic [31:0]       instr_o,
  output logic [XLEN-1:0]   pc_o,
  output logic              fault_o
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned SW = CW + 2;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic [CW-1:0]   count;
  logic [SW-1:0]   in_use;
  logic [XLEN-1:0] target;
  logic            credit, req, accept;
  logic            rsp_any, rsp_drop, push, pop;
  fetch_entry_t    push_data, head;

  assign target = {branch_adr_i[XLEN-1:2], 2'b00};

  // Every FIFO slot is reserved at request time, so the FIFO can never overflow.
  assign in_use  = SW'(count) + SW'(outstanding_q) + SW'(discard_q);
  assign credit  = in_use < SW'(DEPTH);
  assign req     = reset_n && !branch_v_i && credit;
  assign accept  = req && imem.gnt;

  // Responses with nothing in flight are protocol errors and are ignored.
  assign rsp_any  = imem.rvalid && ((outstanding_q != '0) || (discard_q != '0));
  assign rsp_drop = rsp_any && (discard_q != '0);
  assign push     = rsp_any && !rsp_drop && !branch_v_i;
  assign pop      = instr_v_o && instr_ready_i && !branch_v_i;

  assign push_data = '{pc: resp_pc_q, instr: imem.rdata, fault: imem.err};

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    if (branch_v_i) begin
      fetch_pc_d    = target;
      resp_pc_d     = target;
      outstanding_d = '0;
      // Whatever is still in flight after this cycle's response must be dropped.
      discard_d     = discard_q + outstanding_q + CW'(accept) - CW'(rsp_any);
    end else begin
      if (accept) fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (push)   resp_pc_d  = resp_pc_q + XLEN'(4);
      if (rsp_drop) discard_d = discard_q - CW'(1);
      outstanding_d = outstanding_q + CW'(accept) - CW'(push);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_q    <= RESET_VECTOR;
      resp_pc_q     <= RESET_VECTOR;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  ifetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clear_i (branch_v_i),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (count)
  );

  assign imem.req = req;
  assign imem.adr = reset_n ? fetch_pc_q : '0;

  assign instr_v_o = (count != '0);
  assign instr_o   = instr_v_o ? head.instr : '0;
  assign pc_o      = instr_v_o ? head.pc    : '0;
  assign fault_o   = instr_v_o && head.fault;

  rsp_protocol: assert property (@(posedge clk) disable iff (!reset_n)
    imem.rvalid |-> ((outstanding_q != '0) || (discard_q != '0)));

endmodule
